// File: rtl/grf_wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds FSM state encoding, default starvation limit and address width.
package grf_wb_arb_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS = 1 << REG_AW;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard for long-unit destination registers.
// Flags registers whose value is still owed by the mult/div unit.
module grf_scoreboard
    import grf_wb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_a,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_a,
    input  logic [REG_AW-1:0] rs_a,
    input  logic [REG_AW-1:0] rt_a,
    output logic              rs_busy,
    output logic              rt_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_n;

    // Next scoreboard: clear on accepted result, set on issue (set wins).
    always_comb begin
        busy_n = busy;
        if (clr_en) begin
            busy_n[clr_a] = 1'b0;
        end
        if (set_en && (set_a != '0)) begin
            busy_n[set_a] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    // Scoreboard register; $0 never tracked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_n;
        end
    end

    // Lookup with same-cycle bypass: a result written now is not pending.
    always_comb begin
        rs_busy = busy[rs_a] & ~(clr_en && (clr_a == rs_a));
        rt_busy = busy[rt_a] & ~(clr_en && (clr_a == rt_a));
    end

endmodule

// File: rtl/grf_wb_arb.sv
// Register-file write port arbiter between pipeline WB and long unit.
// Pipeline wins by default; a starved long unit forces a pipeline stall.
module grf_wb_arb
    import grf_wb_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_a3,
    input  logic [31:0] wb_wd,
    input  logic [31:0] wb_pc,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_a3,
    input  logic [31:0] lu_wd,
    input  logic [31:0] lu_pc,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_a3,
    input  logic [4:0]  rs_a,
    input  logic [4:0]  rt_a,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        pl_stall,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam logic [4:0] SMAX = 5'(STARVE_MAX);

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [4:0] cnt_inc;
    logic       grant_lu;
    logic       grant_wb;

    // Grant selection; FORCE serves only the long unit, pipeline is held.
    always_comb begin
        grant_lu = 1'b0;
        grant_wb = 1'b0;
        if (!reset) begin
            if (state == S_FORCE) begin
                grant_lu = lu_valid;
            end else if (wb_we) begin
                grant_wb = 1'b1;
            end else begin
                grant_lu = lu_valid;
            end
        end
    end

    assign lu_ready = grant_lu;
    assign pl_stall = (state == S_FORCE) && !reset;

    // Register-file port mux; writes to $0 are consumed but suppressed.
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (grant_lu) begin
            grf_we = (lu_a3 != '0);
            grf_a3 = lu_a3;
            grf_wd = lu_wd;
            grf_pc = lu_pc;
        end else if (grant_wb) begin
            grf_we = (wb_a3 != '0);
            grf_a3 = wb_a3;
            grf_wd = wb_wd;
            grf_pc = wb_pc;
        end
    end

    // Starvation FSM: count consecutive denials, force after the limit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cnt_inc = {1'b0, cnt} + 5'd1;
        unique case (state)
            S_IDLE: begin
                if (lu_valid && !grant_lu) begin
                    cnt_n   = 4'd1;
                    state_n = (5'd1 >= SMAX) ? S_FORCE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (grant_lu) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc[3:0];
                    if (cnt_inc >= SMAX) begin
                        state_n = S_FORCE;
                    end
                end
            end
            S_FORCE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // FSM state and denial counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    grf_scoreboard u_sb (
        .clk     (clk),
        .reset   (reset),
        .set_en  (lu_issue),
        .set_a   (lu_issue_a3),
        .clr_en  (lu_ready),
        .clr_a   (lu_a3),
        .rs_a    (rs_a),
        .rt_a    (rt_a),
        .rs_busy (rs_busy),
        .rt_busy (rt_busy)
    );

endmodule

// File: tb/tb_grf_wb_arb.sv
// Self-checking bench for grf_wb_arb: directed cases plus random traffic
// compared against a behavioural model of arbitration and scoreboard.
module tb_grf_wb_arb;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic [31:0] wb_pc;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_a3;
    logic [31:0] lu_wd;
    logic [31:0] lu_pc;
    logic        lu_issue;
    logic [4:0]  lu_issue_a3;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic        rs_busy;
    logic        rt_busy;
    logic        pl_stall;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int checks = 0;
    int passed = 0;
    int fails = 0;
    string phase = "init";

    // model state
    bit        m_force;
    int        m_den;
    bit [31:0] m_sb;
    bit        m_lr;

    grf_wb_arb #(.STARVE_MAX(SMAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_a3       (wb_a3),
        .wb_wd       (wb_wd),
        .wb_pc       (wb_pc),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_a3       (lu_a3),
        .lu_wd       (lu_wd),
        .lu_pc       (lu_pc),
        .lu_issue    (lu_issue),
        .lu_issue_a3 (lu_issue_a3),
        .rs_a        (rs_a),
        .rt_a        (rt_a),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .pl_stall    (pl_stall),
        .grf_we      (grf_we),
        .grf_a3      (grf_a3),
        .grf_wd      (grf_wd),
        .grf_pc      (grf_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s %s: got %0h want %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        wb_we = 0; wb_a3 = 0; wb_wd = 0; wb_pc = 0;
        lu_valid = 0; lu_a3 = 0; lu_wd = 0; lu_pc = 0;
        lu_issue = 0; lu_issue_a3 = 0; rs_a = 0; rt_a = 0;
    endtask

    task automatic model_reset();
        m_force = 0;
        m_den = 0;
        m_sb = '0;
        m_lr = 0;
    endtask

    // One cycle: inputs already set after a negedge; check, clock, update.
    task automatic cyc();
        int g;
        logic [4:0] ea3;
        logic [31:0] ewd;
        logic [31:0] epc;
        bit ers;
        bit ert;
        #2;
        if (m_force) g = lu_valid ? 2 : 0;
        else if (wb_we) g = 1;
        else if (lu_valid) g = 2;
        else g = 0;
        ea3 = (g == 1) ? wb_a3 : (g == 2) ? lu_a3 : 5'd0;
        ewd = (g == 1) ? wb_wd : (g == 2) ? lu_wd : 32'd0;
        epc = (g == 1) ? wb_pc : (g == 2) ? lu_pc : 32'd0;
        m_lr = (g == 2);
        ers = m_sb[rs_a] && !(m_lr && lu_a3 == rs_a);
        ert = m_sb[rt_a] && !(m_lr && lu_a3 == rt_a);
        chk("lu_ready", 32'(lu_ready), 32'(m_lr));
        chk("pl_stall", 32'(pl_stall), 32'(m_force));
        chk("grf_we", 32'(grf_we), 32'(g != 0 && ea3 != 0));
        chk("grf_a3", 32'(grf_a3), 32'(ea3));
        if (g == 0 || ea3 != 0) begin
            chk("grf_wd", grf_wd, ewd);
            chk("grf_pc", grf_pc, epc);
        end
        chk("rs_busy", 32'(rs_busy), 32'(ers));
        chk("rt_busy", 32'(rt_busy), 32'(ert));
        @(posedge clk);
        if (m_lr) m_sb[lu_a3] = 0;
        if (lu_issue) m_sb[lu_issue_a3] = 1;
        m_sb[0] = 0;
        if (m_force) begin
            m_force = 0;
            m_den = 0;
        end else if (m_lr) begin
            m_den = 0;
        end else if (lu_valid || m_den > 0) begin
            m_den++;
            if (m_den >= SMAX) m_force = 1;
        end
        @(negedge clk);
    endtask

    bit        pend;
    logic [4:0] p_a3;
    logic [31:0] p_wd;
    logic [31:0] p_pc;

    initial begin
        idle_in();
        model_reset();
        reset = 1;
        wb_we = 1; wb_a3 = 7;
        lu_valid = 1; lu_a3 = 6;
        rs_a = 6; rt_a = 7;

        // reset state with live requests
        phase = "reset";
        #3;
        chk("grf_we", 32'(grf_we), 32'd0);
        chk("lu_ready", 32'(lu_ready), 32'd0);
        chk("pl_stall", 32'(pl_stall), 32'd0);
        chk("rs_busy", 32'(rs_busy), 32'd0);
        chk("rt_busy", 32'(rt_busy), 32'd0);
        @(negedge clk);
        reset = 0;
        idle_in();

        // pipeline only
        phase = "pipe";
        wb_we = 1; wb_a3 = 5; wb_wd = 32'h1234; wb_pc = 32'h400;
        #1;
        chk("grf_we", 32'(grf_we), 32'd1);
        chk("grf_a3", 32'(grf_a3), 32'd5);
        chk("grf_wd", grf_wd, 32'h1234);
        cyc();

        // starvation: four denials then forced cycle
        phase = "starve";
        wb_we = 1; wb_a3 = 2; wb_wd = 32'haa;
        lu_valid = 1; lu_a3 = 8; lu_wd = 32'hbeef; lu_pc = 32'h800;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("denied", 32'(lu_ready), 32'd0);
            cyc();
        end
        #1;
        chk("force_stall", 32'(pl_stall), 32'd1);
        chk("force_rdy", 32'(lu_ready), 32'd1);
        chk("force_a3", 32'(grf_a3), 32'd8);
        cyc();
        lu_valid = 0;
        #1;
        chk("post_idle", 32'(pl_stall), 32'd0);
        cyc();

        // scoreboard set and bypassed clear
        phase = "sb";
        idle_in();
        lu_issue = 1; lu_issue_a3 = 9;
        cyc();
        lu_issue = 0; rs_a = 9; rt_a = 9;
        #1;
        chk("rs_set", 32'(rs_busy), 32'd1);
        cyc();
        lu_valid = 1; lu_a3 = 9; lu_wd = 32'h99;
        #1;
        chk("rs_byp", 32'(rs_busy), 32'd0);
        cyc();
        lu_valid = 0;
        #1;
        chk("rs_clr", 32'(rs_busy), 32'd0);
        cyc();

        // $0 handling
        phase = "zero";
        idle_in();
        lu_valid = 1; lu_a3 = 0; lu_wd = 32'h55;
        lu_issue = 1; lu_issue_a3 = 0;
        #1;
        chk("z_rdy", 32'(lu_ready), 32'd1);
        chk("z_we", 32'(grf_we), 32'd0);
        cyc();
        idle_in();
        cyc();

        // simultaneous set and clear of same register
        phase = "setclr";
        lu_issue = 1; lu_issue_a3 = 3;
        cyc();
        lu_valid = 1; lu_a3 = 3;
        lu_issue = 1; lu_issue_a3 = 3;
        cyc();
        idle_in();
        rs_a = 3;
        #1;
        chk("set_wins", 32'(rs_busy), 32'd1);
        cyc();
        lu_valid = 1; lu_a3 = 3;
        cyc();
        idle_in();

        // reset in WAIT with cnt=2 and busy[4]
        phase = "midrst";
        lu_issue = 1; lu_issue_a3 = 4;
        cyc();
        lu_issue = 0;
        wb_we = 1; wb_a3 = 1; lu_valid = 1; lu_a3 = 10;
        cyc();
        cyc();
        rs_a = 4;
        #2;
        reset = 1;
        #1;
        chk("r_stall", 32'(pl_stall), 32'd0);
        chk("r_busy", 32'(rs_busy), 32'd0);
        chk("r_rdy", 32'(lu_ready), 32'd0);
        chk("r_we", 32'(grf_we), 32'd0);
        @(negedge clk);
        reset = 0;
        model_reset();
        idle_in();
        rs_a = 4;
        wb_we = 1; wb_a3 = 1;
        #1;
        chk("after_busy", 32'(rs_busy), 32'd0);
        chk("after_idle", 32'(pl_stall), 32'd0);
        cyc();
        // fresh request needs a full four denials again
        lu_valid = 1; lu_a3 = 11;
        for (int i = 0; i < 4; i++) cyc();
        lu_valid = 0;
        cyc();

        // random traffic against the model
        phase = "rand";
        idle_in();
        pend = 0;
        for (int i = 0; i < 800; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1;
                p_a3 = 5'($urandom_range(0, 7));
                p_wd = $urandom;
                p_pc = $urandom;
            end
            lu_valid = pend;
            lu_a3 = pend ? p_a3 : 5'($urandom_range(0, 31));
            lu_wd = pend ? p_wd : $urandom;
            lu_pc = pend ? p_pc : $urandom;
            wb_we = ($urandom_range(0, 3) != 0);
            wb_a3 = 5'($urandom_range(0, 31));
            wb_wd = $urandom;
            wb_pc = $urandom;
            lu_issue = ($urandom_range(0, 3) == 0);
            lu_issue_a3 = 5'($urandom_range(0, 7));
            rs_a = 5'($urandom_range(0, 7));
            rt_a = 5'($urandom_range(0, 7));
            cyc();
            if (m_lr) pend = 0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
